mult_datapath: RTL and testbench



---
 rtl/mult_datapath.sv | 129 ++++++++++++
 tb/tb_mult_datapath.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// mult_datapath: register and arithmetic datapath for the 8-bit signed
// add-shift multiplier. It holds the accumulator A, the multiplier B and the
// sign-extension bit X. It decodes the control FSM strobes and returns B[0]
// to the FSM as M.
//
// Optional feature: define MULT_SHIFT_COUNT_EN to build the 3-bit shift
// counter that drives Shift_cnt and Last. Without it, both outputs are tied
// to zero and the FSM has to count shifts itself.
module mult_datapath (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] S,
    input  logic       Clr_Ld,
    input  logic       ADD,
    input  logic       SUB,
    input  logic       Shift,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       M,
    output logic [2:0] Shift_cnt,
    output logic       Last
);

    // One operation per cycle; the priority encoder below picks it.
    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SUB   = 3'd2,
        OP_ADD   = 3'd3,
        OP_SHIFT = 3'd4
    } op_e;

    op_e        op;
    logic [7:0] a_q, b_q;
    logic       x_q;
    logic [7:0] a_d, b_d;
    logic       x_d;
    logic [8:0] a_ext, s_ext, sum9, diff9;

    // Strobe priority: Clr_Ld > SUB > ADD > Shift. Reset is handled in the
    // register blocks and overrides everything.
    always_comb begin
        op = OP_HOLD;
        if (Clr_Ld)     op = OP_LOAD;
        else if (SUB)   op = OP_SUB;
        else if (ADD)   op = OP_ADD;
        else if (Shift) op = OP_SHIFT;
    end

    // 9-bit signed arithmetic. Two 8-bit operands cannot overflow 9 bits,
    // so bit 8 is always the true sign of the result.
    always_comb begin
        a_ext = {a_q[7], a_q};
        s_ext = {S[7], S};
        sum9  = a_ext + s_ext;
        diff9 = a_ext + ~s_ext + 9'd1;
    end

    // Next values of A, B and X for the selected operation.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        unique case (op)
            OP_LOAD: begin
                a_d = 8'h00;
                b_d = S;
                x_d = 1'b0;
            end
            OP_SUB: begin
                a_d = diff9[7:0];
                x_d = diff9[8];
            end
            OP_ADD: begin
                a_d = sum9[7:0];
                x_d = sum9[8];
            end
            OP_SHIFT: begin
                // Arithmetic right shift of {X,A,B}. X keeps its value and
                // acts as the sign fill.
                a_d = {x_q, a_q[7:1]};
                b_d = {a_q[0], b_q[7:1]};
            end
            default: begin
                a_d = a_q;
                b_d = b_q;
                x_d = x_q;
            end
        endcase
    end

    // A/B/X registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q <= 8'h00;
            b_q <= 8'h00;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

`ifdef MULT_SHIFT_COUNT_EN
    logic [2:0] cnt_q;

    // Shift counter: cleared by reset or load, and counts up once per
    // executed shift. It wraps 7 -> 0, so the eighth shift returns it to 0.
    always_ff @(posedge Clk) begin
        if (Reset)                cnt_q <= 3'd0;
        else if (op == OP_LOAD)   cnt_q <= 3'd0;
        else if (op == OP_SHIFT)  cnt_q <= cnt_q + 3'd1;
    end

    assign Shift_cnt = cnt_q;
    assign Last      = (cnt_q == 3'd7);
`else
    assign Shift_cnt = 3'd0;
    assign Last      = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Testbench for mult_datapath: a table of single-cycle directed vectors,
// then hand-written multi-cycle sequences (a full multiply and a reset
// during a run). The counter expectations follow MULT_SHIFT_COUNT_EN.
module tb_mult_datapath;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] S;
    logic       Clr_Ld, ADD, SUB, Shift;
    logic [7:0] Aval, Bval;
    logic       X, M, Last;
    logic [2:0] Shift_cnt;

    int checks   = 0;
    int failures = 0;

    mult_datapath dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .S         (S),
        .Clr_Ld    (Clr_Ld),
        .ADD       (ADD),
        .SUB       (SUB),
        .Shift     (Shift),
        .Aval      (Aval),
        .Bval      (Bval),
        .X         (X),
        .M         (M),
        .Shift_cnt (Shift_cnt),
        .Last      (Last)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       rst, clr, add, sub, sh;
        logic [7:0] s;
        logic [7:0] a, b;
        logic       x;
        int         cnt;   // counter value when the counter is built
    } vec_t;

    vec_t vecs[15];

    function automatic int exp_cnt(input int c);
`ifdef MULT_SHIFT_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] a,
                             input logic [7:0] b, input logic x, input int cnt);
        chk({name, ".A"},    int'(Aval),      int'(a));
        chk({name, ".B"},    int'(Bval),      int'(b));
        chk({name, ".X"},    int'(X),         int'(x));
        chk({name, ".M"},    int'(M),         int'(b[0]));
        chk({name, ".cnt"},  int'(Shift_cnt), exp_cnt(cnt));
        chk({name, ".Last"}, int'(Last),      (exp_cnt(cnt) == 7) ? 1 : 0);
    endtask

    task automatic drive(input logic rst, input logic clr, input logic add,
                         input logic sub, input logic sh, input logic [7:0] s);
        Reset = rst; Clr_Ld = clr; ADD = add; SUB = sub; Shift = sh; S = s;
    endtask

    // Apply the current inputs over one rising edge and return #1 after it.
    task automatic cycle();
        @(posedge Clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        //           name        rst clr add sub sh  S      A      B      X  cnt
        vecs[0]  = '{"rst_all",  1,  1,  1,  1,  1,  8'h5A, 8'h00, 8'h00, 0, 0};
        vecs[1]  = '{"load07",   0,  1,  0,  0,  0,  8'h07, 8'h00, 8'h07, 0, 0};
        vecs[2]  = '{"add05",    0,  0,  1,  0,  0,  8'h05, 8'h05, 8'h07, 0, 0};
        vecs[3]  = '{"reload07", 0,  1,  0,  0,  0,  8'h07, 8'h00, 8'h07, 0, 0};
        vecs[4]  = '{"sub05",    0,  0,  0,  1,  0,  8'h05, 8'hFB, 8'h07, 1, 0};
        vecs[5]  = '{"shift1",   0,  0,  0,  0,  1,  8'h00, 8'hFD, 8'h83, 1, 1};
        vecs[6]  = '{"idle",     0,  0,  0,  0,  0,  8'hAA, 8'hFD, 8'h83, 1, 1};
        vecs[7]  = '{"load00",   0,  1,  0,  0,  0,  8'h00, 8'h00, 8'h00, 0, 0};
        vecs[8]  = '{"addsub",   0,  0,  1,  1,  0,  8'h01, 8'hFF, 8'h00, 1, 0};
        vecs[9]  = '{"ldshift",  0,  1,  0,  0,  1,  8'h33, 8'h00, 8'h33, 0, 0};
        vecs[10] = '{"add80",    0,  0,  1,  0,  0,  8'h80, 8'h80, 8'h33, 1, 0};
        vecs[11] = '{"add80b",   0,  0,  1,  0,  0,  8'h80, 8'h00, 8'h33, 1, 0};
        vecs[12] = '{"sub7F",    0,  0,  0,  1,  0,  8'h7F, 8'h81, 8'h33, 1, 0};
        vecs[13] = '{"addshift", 0,  0,  1,  0,  1,  8'h01, 8'h82, 8'h33, 1, 0};
        vecs[14] = '{"rstshift", 1,  0,  0,  0,  1,  8'h11, 8'h00, 8'h00, 0, 0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].add, vecs[i].sub,
                  vecs[i].sh, vecs[i].s);
            cycle();
            check_all(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].cnt);
        end

        // Full multiply: 3 * (-2). The multiplier bits come from the known
        // operand, not from M. ADD when the bit is 1 for bits 0..6, SUB for bit 7.
        begin
            logic [7:0] mplier;
            mplier = 8'hFE;
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mplier);
            cycle();
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("mul.M%0d", i), int'(M), int'(mplier[i]));
                if (mplier[i]) begin
                    drive(1'b0, 1'b0, i < 7, i == 7, 1'b0, 8'h03);
                    cycle();
                end
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
                cycle();
                chk($sformatf("mul.cnt%0d", i), int'(Shift_cnt), exp_cnt((i + 1) % 8));
                chk($sformatf("mul.last%0d", i), int'(Last), (exp_cnt((i + 1) % 8) == 7) ? 1 : 0);
            end
            check_all("mul_final", 8'hFF, 8'hFA, 1'b1, 0);
        end

        // Reset in the middle of a run, with other strobes active.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC5);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h21);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle();
        check_all("mid_pre", 8'h10, 8'hE2, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77);
        cycle();
        check_all("mid_rst", 8'h00, 8'h00, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
